// File: rtl/alu_pkg.sv
// alu_pkg -- shared ALU definitions.
// Holds the datapath width, the ALUControl code enum (also used by the ALU
// decoder), the bit-count mode enum, the exec FSM state enum and the
// single-cycle ALU function.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_SLT    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_XOR    = 4'b1010,
    ALU_SLTU   = 4'b1100,
    ALU_EQ     = 4'b1101,
    ALU_SLL    = 4'b1110,
    ALU_BITCNT = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    BIT_CLZ  = 2'b00,
    BIT_CTZ  = 2'b01,
    BIT_CPOP = 2'b10
  } bitop_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Single-cycle operations. Bit-count and unassigned codes return 0 here;
  // bit-count, when built in, is produced by the serial counter instead.
  function automatic logic [XLEN-1:0] alu_comb(input logic [3:0]      ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    res = '0;
    case (ctrl)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_EQ:   res = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_bitcnt.sv
// alu_bitcnt -- nibble-serial clz / ctz / cpop.
// Ports:
//   clk, reset        clock, async active-high reset
//   start             capture operand and mode, begin counting
//   operand[31:0]     value to count
//   mode[1:0]         00 clz, 01 ctz, 10 cpop
//   count[5:0]        final count, valid while done=1
//   done              high during the 8th processing cycle (step 7)
// One nibble per cycle for 8 cycles. clz walks from the MSB, ctz/cpop from
// the LSB; the operand is shifted so the active nibble is always at a fixed
// position. count includes the current nibble so the caller can register it
// on the same edge that finishes step 7.
module alu_bitcnt
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] operand,
  input  logic [1:0]      mode,
  output logic [5:0]      count,
  output logic            done
);

  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [1:0]      mode_q, mode_d;
  logic [2:0]      step_q, step_d;
  logic            busy_q, busy_d;
  logic            found_q, found_d;
  logic [5:0]      cnt_q, cnt_d;

  logic [3:0] nib;
  logic [5:0] contrib;
  logic [5:0] cnt_next;

  function automatic logic [2:0] lz4(input logic [3:0] n);
    if (n[3])      return 3'd0;
    else if (n[2]) return 3'd1;
    else if (n[1]) return 3'd2;
    else if (n[0]) return 3'd3;
    else           return 3'd4;
  endfunction

  function automatic logic [2:0] tz4(input logic [3:0] n);
    if (n[0])      return 3'd0;
    else if (n[1]) return 3'd1;
    else if (n[2]) return 3'd2;
    else if (n[3]) return 3'd3;
    else           return 3'd4;
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] n);
    return {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  always_comb begin
    nib = (mode_q == BIT_CLZ) ? opnd_q[XLEN-1 -: 4] : opnd_q[3:0];
    contrib = '0;
    case (mode_q)
      BIT_CLZ:  contrib = found_q ? 6'd0 : {3'b000, lz4(nib)};
      BIT_CTZ:  contrib = found_q ? 6'd0 : {3'b000, tz4(nib)};
      BIT_CPOP: contrib = {3'b000, pop4(nib)};
      default:  contrib = '0;
    endcase
    cnt_next = cnt_q + contrib;
  end

  assign count = cnt_next;
  assign done  = busy_q && (step_q == 3'd7);

  always_comb begin
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    step_d  = step_q;
    busy_d  = busy_q;
    found_d = found_q;
    cnt_d   = cnt_q;
    if (start) begin
      opnd_d  = operand;
      mode_d  = mode;
      step_d  = '0;
      busy_d  = 1'b1;
      found_d = 1'b0;
      cnt_d   = '0;
    end else if (busy_q) begin
      opnd_d  = (mode_q == BIT_CLZ) ? (opnd_q << 4) : (opnd_q >> 4);
      found_d = found_q || (nib != 4'h0);
      cnt_d   = cnt_next;
      step_d  = step_q + 3'd1;
      if (step_q == 3'd7) begin
        busy_d = 1'b0;
        step_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd_q  <= '0;
      mode_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      found_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec -- registered ALU execute stage with valid/ready handshakes.
// Ports:
//   clk, reset              clock, async active-high reset
//   in_valid / in_ready     operation handshake
//   alu_ctrl[3:0]           ALUControl code
//   bitop_sel[1:0]          bit-count mode (00 clz, 01 ctz, 10 cpop)
//   src_a, src_b [31:0]     operands
//   out_valid / out_ready   result handshake
//   result[31:0], zero      registered result and result==0 flag
// Build option: define ALU_BITCNT_EN to include the serial bit-count unit
// (alu_ctrl=1111, 8-cycle latency). Without it 1111 is a single-cycle op
// returning 0 and the exec stage has no COUNT state.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accepting ops whenever the output slot is free or draining
// ST_COUNT | bit-count in progress; output slot empty, no new ops taken
module alu_exec
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [1:0]      bitop_sel,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            slot_free;
  logic            accept;

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;

`ifdef ALU_BITCNT_EN
  state_e     state_q, state_d;
  logic       bc_start;
  logic       bc_done;
  logic [5:0] bc_count;

  assign in_ready = (state_q == ST_IDLE) && slot_free;
  assign bc_start = accept && (alu_ctrl == ALU_BITCNT);

  alu_bitcnt u_bitcnt (
    .clk     (clk),
    .reset   (reset),
    .start   (bc_start),
    .operand (src_a),
    .mode    (bitop_sel),
    .count   (bc_count),
    .done    (bc_done)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    // A consumed result is dropped unless a new one lands on the same edge.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alu_ctrl == ALU_BITCNT) begin
            state_d = ST_COUNT;
          end else begin
            result_d    = alu_comb(alu_ctrl, src_a, src_b);
            zero_d      = (alu_comb(alu_ctrl, src_a, src_b) == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      ST_COUNT: begin
        if (bc_done) begin
          result_d    = {{(XLEN-6){1'b0}}, bc_count};
          zero_d      = (bc_count == 6'd0);
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end
`else
  logic unused_bitop;
  assign unused_bitop = ^bitop_sel;

  assign in_ready = slot_free;

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      result_d    = alu_comb(alu_ctrl, src_a, src_b);
      zero_d      = (alu_comb(alu_ctrl, src_a, src_b) == '0);
      out_valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  bitop_sel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

`ifdef ALU_BITCNT_EN
  localparam bit BITCNT = 1'b1;
`else
  localparam bit BITCNT = 1'b0;
`endif

  alu_exec dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .bitop_sel (bitop_sel),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: operation semantics from the code table, plain arithmetic.
  function automatic logic [31:0] bit_count(input logic [1:0] sel, input logic [31:0] a);
    int n;
    n = 0;
    if (sel == 2'd0) begin
      for (int i = 31; i >= 0; i--) begin
        if (a[i]) break;
        n++;
      end
    end else if (sel == 2'd1) begin
      for (int i = 0; i < 32; i++) begin
        if (a[i]) break;
        n++;
      end
    end else if (sel == 2'd2) begin
      for (int i = 0; i < 32; i++) n += int'(a[i]);
    end
    return 32'(n);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [1:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'hA: return a ^ b;
      4'h5: return (sa < sb) ? 32'd1 : 32'd0;
      4'hC: return (a < b) ? 32'd1 : 32'd0;
      4'hD: return (a == b) ? 32'd1 : 32'd0;
      4'hE: return a << sh;
      4'h6: return a >> sh;
      4'h7: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'hF: return BITCNT ? bit_count(sel, a) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Timing model: one output slot, bit-count busy for 8 edges.
  int          wait_left = 0;
  logic        m_ov = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  task automatic model_reset();
    wait_left = 0;
    m_ov      = 1'b0;
    m_res     = '0;
    m_pend    = '0;
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, advance one edge.
  task automatic step(input logic iv, input logic [3:0] c, input logic [1:0] sel,
                      input logic [31:0] a, input logic [31:0] b, input logic ordy);
    logic m_rdy;
    logic acc;
    in_valid  = iv;
    alu_ctrl  = c;
    bitop_sel = sel;
    src_a     = a;
    src_b     = b;
    out_ready = ordy;
    #1;
    m_rdy = (wait_left == 0) && (!m_ov || ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      check("result", result, m_res);
      check("zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
    end
    acc = iv && m_rdy;
    if (m_ov && ordy) m_ov = 1'b0;
    if (wait_left > 0) begin
      wait_left--;
      if (wait_left == 0) begin
        m_ov  = 1'b1;
        m_res = m_pend;
      end
    end else if (acc) begin
      if (c == 4'hF && BITCNT) begin
        wait_left = 8;
        m_pend    = ref_alu(c, sel, a, b);
      end else begin
        m_ov  = 1'b1;
        m_res = ref_alu(c, sel, a, b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 2'd0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] ctrl_pool [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'h5, 4'hC, 4'hD,
                                 4'hE, 4'h6, 4'h7, 4'hF, 4'h4, 4'h8, 4'h9, 4'hB};

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_ctrl = '0; bitop_sel = '0;
    src_a = '0; src_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // add overflow wraps
    step(1'b1, 4'h0, 2'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    check("add_ovf_valid", {31'd0, out_valid}, 32'd1);
    check("add_ovf_result", result, 32'h80000000);
    check("add_ovf_zero", {31'd0, zero}, 32'd0);

    // back-to-back sra then slt
    step(1'b1, 4'h7, 2'd0, 32'h80000010, 32'd4, 1'b1);
    check("sra_result", result, 32'hF8000001);
    step(1'b1, 4'h5, 2'd0, 32'hFFFFFFFF, 32'd1, 1'b1);
    check("slt_result", result, 32'd1);
    check("slt_valid", {31'd0, out_valid}, 32'd1);
    idle(1);

    if (BITCNT) begin
      // clz: 8 busy cycles, inputs toggling underneath must not matter
      step(1'b1, 4'hF, 2'd0, 32'h00010000, 32'd0, 1'b1);
      for (int i = 0; i < 8; i++) begin
        check("clz_busy_in_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 4'hF, 2'(i % 3), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      check("clz_valid", {31'd0, out_valid}, 32'd1);
      check("clz_result", result, 32'd15);
      step(1'b1, 4'hF, 2'd2, 32'hFFFFFFFF, 32'd0, 1'b1);
      idle(8);
      check("cpop_result", result, 32'd32);
      step(1'b1, 4'hF, 2'd1, 32'h00000000, 32'd0, 1'b1);
      idle(8);
      check("ctz0_result", result, 32'd32);
      check("ctz0_zero", {31'd0, zero}, 32'd0);
      idle(1);
    end else begin
      step(1'b1, 4'hF, 2'd0, 32'h00010000, 32'd0, 1'b1);
      check("bitcnt_off_valid", {31'd0, out_valid}, 32'd1);
      check("bitcnt_off_result", result, 32'd0);
      check("bitcnt_off_zero", {31'd0, zero}, 32'd1);
      idle(1);
    end

    // stall: eq held for 5 cycles, next op taken on the drain edge
    step(1'b1, 4'hD, 2'd0, 32'd5, 32'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_result", result, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 4'h0, 2'd0, 32'd2, 32'd3, 1'b0);
    end
    step(1'b1, 4'h0, 2'd0, 32'd2, 32'd3, 1'b1);
    check("drain_next_result", result, 32'd5);
    check("drain_next_valid", {31'd0, out_valid}, 32'd1);
    idle(1);

    // reset during bit-count (after 4 steps processed)
    if (BITCNT) begin
      step(1'b1, 4'hF, 2'd2, 32'h12345678, 32'd0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 2'd0, 32'd0, 32'd0, 1'b1);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_zero", {31'd0, zero}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      idle(12);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: b = a;
        2: a = 32'h80000000;
        default: ;
      endcase
      step(1'($urandom_range(0, 3) != 0), ctrl_pool[$urandom_range(0, 15)],
           2'($urandom_range(0, 2)), a, b, 1'($urandom_range(0, 3) != 0));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
